fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the DLX pipeline. It owns the program counter and drives the instruction SRAM request/acknowledge interface. It resolves redirect and hold requests from later stages: branch from EX, stall from ID control, and optionally a trap. It presents a valid/instruction/PC triple to the IF/ID latch and kills wrong-path fetches.

---
 rtl/dlx_fetch_pkg.sv | 20 ++
 rtl/fetch_ctrl_if.sv | 26 ++
 rtl/fetch_skid.sv | 51 +++++
 rtl/fetch_ctrl.sv | 178 +++++++++++++++++
 tb/tb_fetch_ctrl.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dlx_fetch_pkg.sv
// dlx_fetch_pkg: shared definitions for the DLX instruction-fetch sequencer.
//   - FSM state encoding (BOOT, FETCH, HOLD, DRAIN)
//   - default reset PC and trap vector
//   - word_align helper used on redirect targets
package dlx_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0100;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Redirect targets are word addresses; the byte-offset bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction SRAM request/acknowledge bus.
//   imem_req  : read request, held with imem_addr until the ack cycle
//   imem_addr : read address
//   imem_ack  : read data valid this cycle
//   imem_data : instruction word
// Modports: master (fetch sequencer), slave (SRAM).
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );
endinterface

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry instruction/PC buffer.
//   clk, reset             : clock, synchronous active-high reset
//   load                   : capture load_instr/load_pc, mark valid
//   clear                  : drop the entry (wins over load)
//   valid, instr, pc       : buffered entry
module fetch_skid (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q,    pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      pc_d    = load_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: DLX instruction-fetch sequencer.
// Owns the PC, drives the instruction SRAM bus and presents
// valid/instr/pc to the IF/ID latch. Handles branch/trap redirects
// (wrong-path data is killed) and ID stalls (word parked in a skid buffer).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   branch, branch_pc     : taken branch from EX and its target
//   stall                 : ID hazard hold
//   trap                  : trap redirect (only with FETCH_CTRL_TRAP_EN)
//   imem                  : SRAM bus (fetch_ctrl_if.master)
//   if_valid/instr/pc     : IF/ID output triple
// Build option: define FETCH_CTRL_TRAP_EN to add the trap port and TRAP_VEC.
module fetch_ctrl
  import dlx_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
`ifdef FETCH_CTRL_TRAP_EN
  ,
  parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEFAULT
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               branch,
  input  logic [31:0]        branch_pc,
  input  logic               stall,
`ifdef FETCH_CTRL_TRAP_EN
  input  logic               trap,
`endif
  fetch_ctrl_if.master       imem,
  output logic               if_valid,
  output logic [31:0]        if_instr,
  output logic [31:0]        if_pc
);

  logic [1:0]  state_q,    state_d;
  logic [31:0] pc_q,       pc_d;
  logic [31:0] pending_q,  pending_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q,    if_pc_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_inc;

  logic        skid_load;
  logic        skid_clear;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  fetch_skid u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (skid_load),
    .clear      (skid_clear),
    .load_instr (imem.imem_data),
    .load_pc    (pc_q),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  // Trap outranks branch; both are handled identically afterwards.
  always_comb begin
`ifdef FETCH_CTRL_TRAP_EN
    redirect = trap | branch;
    target   = trap ? TRAP_VEC : word_align(branch_pc);
`else
    redirect = branch;
    target   = word_align(branch_pc);
`endif
  end

  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pending_d  = pending_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        if (redirect) begin
          if_valid_d = 1'b0;
          if (imem.imem_ack) begin
            pc_d = target;
          end else begin
            // Request cannot be aborted: remember the target, drain the old one.
            pending_d = target;
            state_d   = ST_DRAIN;
          end
        end else if (imem.imem_ack) begin
          pc_d = pc_inc;
          if (stall) begin
            skid_load = 1'b1;
            state_d   = ST_HOLD;
          end else begin
            if_valid_d = 1'b1;
            if_instr_d = imem.imem_data;
            if_pc_d    = pc_q;
          end
        end else if (!stall) begin
          // Previous word consumed by ID and nothing new arrived.
          if_valid_d = 1'b0;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          if_valid_d = 1'b0;
          skid_clear = 1'b1;
          pc_d       = target;
          state_d    = ST_FETCH;
        end else if (!stall) begin
          if_valid_d = skid_valid;
          if_instr_d = skid_instr;
          if_pc_d    = skid_pc;
          skid_clear = 1'b1;
          state_d    = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        if_valid_d = 1'b0;
        if (redirect) begin
          pending_d = target;
        end
        if (imem.imem_ack) begin
          // A redirect arriving in the ack cycle is the latest one and wins.
          pc_d    = redirect ? target : pending_q;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pending_q  <= '0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pending_q  <= pending_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  // Bus outputs come straight from state/pc registers.
  assign imem.imem_req  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign imem.imem_addr = pc_q;

  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TB_TRAP_VEC = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        branch = 1'b0;
  logic [31:0] branch_pc = '0;
  logic        stall = 1'b0;
  logic        trap = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int unsigned waits = 0;
  int unsigned wcnt;
  logic        force_ack = 1'b0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .RESET_PC (TB_RESET_PC)
`ifdef FETCH_CTRL_TRAP_EN
    ,
    .TRAP_VEC (TB_TRAP_VEC)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .branch    (branch),
    .branch_pc (branch_pc),
    .stall     (stall),
`ifdef FETCH_CTRL_TRAP_EN
    .trap      (trap),
`endif
    .imem      (bus.master),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_pc     (if_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // SRAM model: ack after 'waits' wait states; force_ack injects a stray ack.
  always_comb begin
    bus.imem_ack  = force_ack | (bus.imem_req && (wcnt == waits));
    bus.imem_data = force_ack ? 32'h0BAD_C0DE :
                    (bus.imem_ack ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF);
  end

  always_ff @(posedge clk) begin
    if (reset || !bus.imem_req || bus.imem_ack) wcnt <= 0;
    else                                        wcnt <= wcnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timeout at %0t", name, $time);
  endtask

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.pc    = a;
    e.instr = mem_word(a);
    exp_q.push_back(e);
  endtask

  // Monitor: ID consumes the IF/ID word whenever it is valid and not stalled.
  logic        pend_v = 1'b0;
  logic [31:0] pend_addr = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset && if_valid && !stall && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_pc", if_pc, e.pc);
      check("sb_instr", if_instr, e.instr);
    end
    if (pend_v) begin
      check("bus_req_held", {31'd0, bus.imem_req}, 32'd1);
      check("bus_addr_held", bus.imem_addr, pend_addr);
    end
    pend_v    = bus.imem_req && !bus.imem_ack && !reset;
    pend_addr = bus.imem_addr;
  end

  // Leaves reset asserted, just after a posedge.
  task automatic start(input int unsigned w);
    @(posedge clk); #1;
    reset = 1'b1; branch = 1'b0; stall = 1'b0; trap = 1'b0; force_ack = 1'b0;
    waits = w;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
  endtask

  task automatic wait_q_empty(input string name);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk);
    end
    timeout_fail(name);
    exp_q.delete();
  endtask

  task automatic wait_valid_pc(input logic [31:0] a);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (if_valid && if_pc == a) return;
    end
    timeout_fail("wait_valid_pc");
  endtask

  task automatic wait_ack_addr(input logic [31:0] a);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.imem_ack && bus.imem_addr == a) return;
    end
    timeout_fail("wait_ack_addr");
  endtask

  task automatic wait_addr_change(input logic [31:0] old_a, output logic [31:0] new_a);
    new_a = old_a;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_addr != old_a) begin
        new_a = bus.imem_addr;
        return;
      end
    end
    timeout_fail("wait_addr_change");
  endtask

  initial begin
    logic [31:0] na;

    // 1: reset values, zero-wait sequential fetch
    start(0);
    @(negedge clk);
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_addr", bus.imem_addr, TB_RESET_PC);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_pc", if_pc, 32'd0);
    push(32'h0); push(32'h4); push(32'h8); push(32'hC); push(32'h10);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("boot_req", {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk);
    check("c2_addr", bus.imem_addr, 32'h0);
    check("c2_valid", {31'd0, if_valid}, 32'd0);
    @(negedge clk);
    check("c3_valid", {31'd0, if_valid}, 32'd1);
    check("c3_addr", bus.imem_addr, 32'h4);
    @(negedge clk);
    check("c4_addr", bus.imem_addr, 32'h8);
    @(negedge clk);
    check("c5_addr", bus.imem_addr, 32'hC);
    wait_q_empty("seq_drain");

    // 2: two wait states, stall pulsed for 3 cycles during a request
    start(2);
    push(32'h0); push(32'h4); push(32'h8); push(32'hC);
    reset = 1'b0;
    wait_valid_pc(32'h0);
    @(posedge clk); #1 stall = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("hold_req", {31'd0, bus.imem_req}, 32'd0);
    check("hold_pc", bus.imem_addr, 32'h8);
    @(posedge clk); #1 stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("release_valid", {31'd0, if_valid}, 32'd1);
    check("release_pc", if_pc, 32'h4);
    check("release_addr", bus.imem_addr, 32'h8);
    wait_q_empty("stall_drain");

    // 3: branch while request to 0x8 waits
    start(2);
    push(32'h0); push(32'h4); push(32'h40); push(32'h44);
    reset = 1'b0;
    wait_ack_addr(32'h4);
    @(posedge clk); #1 branch = 1'b1; branch_pc = 32'h0000_0043;
    @(posedge clk); #1 branch = 1'b0;
    @(negedge clk);
    check("br_kill_valid", {31'd0, if_valid}, 32'd0);
    check("br_old_addr", bus.imem_addr, 32'h8);
    wait_addr_change(32'h8, na);
    check("br_target_addr", na, 32'h40);
    wait_q_empty("branch_drain");

    // 4: two branches during one drain, latest wins
    start(2);
    push(32'h0); push(32'h4); push(32'h80); push(32'h84);
    reset = 1'b0;
    wait_ack_addr(32'h4);
    @(posedge clk); #1 branch = 1'b1; branch_pc = 32'h0000_0040;
    @(posedge clk); #1 branch_pc = 32'h0000_0080;
    @(posedge clk); #1 branch = 1'b0;
    @(negedge clk);
    check("dbl_old_addr", bus.imem_addr, 32'h8);
    wait_addr_change(32'h8, na);
    check("dbl_target_addr", na, 32'h80);
    wait_q_empty("dbl_drain");

    // 5: zero-wait redirect penalty and PC wraparound
    start(0);
    push(32'h0); push(32'h4); push(32'hFFFF_FFF8); push(32'hFFFF_FFFC);
    push(32'h0); push(32'h4);
    reset = 1'b0;
    wait_valid_pc(32'h0);
    @(posedge clk); #1 branch = 1'b1; branch_pc = 32'hFFFF_FFF8;
    @(posedge clk); #1 branch = 1'b0;
    @(negedge clk);
    check("wrap_kill_valid", {31'd0, if_valid}, 32'd0);
    check("wrap_target_addr", bus.imem_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    check("wrap_penalty_valid", {31'd0, if_valid}, 32'd1);
    check("wrap_penalty_pc", if_pc, 32'hFFFF_FFF8);
    @(negedge clk);
    check("wrap_addr", bus.imem_addr, 32'h0);
    wait_q_empty("wrap_drain");

    // 6: reset mid-request, stray ack in BOOT ignored
    start(3);
    push(32'h0);
    reset = 1'b0;
    wait_q_empty("mid_first");
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_addr == 32'h4 && !bus.imem_ack) break;
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("mid_rst_addr", bus.imem_addr, TB_RESET_PC);
    check("mid_rst_valid", {31'd0, if_valid}, 32'd0);
    push(32'h0); push(32'h4);
    @(posedge clk); #1 reset = 1'b0; force_ack = 1'b1;
    @(posedge clk); #1 force_ack = 1'b0;
    @(negedge clk);
    check("mid_refetch_addr", bus.imem_addr, TB_RESET_PC);
    check("mid_refetch_req", {31'd0, bus.imem_req}, 32'd1);
    check("mid_refetch_valid", {31'd0, if_valid}, 32'd0);
    wait_q_empty("mid_drain");

`ifdef FETCH_CTRL_TRAP_EN
    // 7: trap and branch together -> trap vector
    start(0);
    push(32'h0); push(32'h4); push(TB_TRAP_VEC); push(TB_TRAP_VEC + 32'd4);
    reset = 1'b0;
    wait_valid_pc(32'h0);
    @(posedge clk); #1 branch = 1'b1; trap = 1'b1; branch_pc = 32'h0000_0040;
    @(posedge clk); #1 branch = 1'b0; trap = 1'b0;
    @(negedge clk);
    check("trap_kill_valid", {31'd0, if_valid}, 32'd0);
    check("trap_addr", bus.imem_addr, TB_TRAP_VEC);
    wait_q_empty("trap_drain");
`endif

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
